// File: rtl/transmissor_paridade.sv
// transmissor_paridade: accepts a 5-bit word over valid/ready, appends an
// even-parity bit and serialises the frame (start, 5 data LSB first, parity,
// stop). The registered 6-bit word is also presented for parity loopback.
//
// Handshake: a word is accepted on a rising edge where valido && pronto.
// pronto is high only while idle; the requester must hold valido (and dados)
// until it sees that edge. valido while busy is ignored, and nothing is queued.
module transmissor_paridade #(
  parameter int CICLOS_POR_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] dados,
  input  logic       valido,
  output logic       pronto,
  output logic       serial_out,
  output logic       ocupado,
  output logic [5:0] quadro,
  output logic [2:0] estado_dbg
);

  localparam int BW = (CICLOS_POR_BIT < 2) ? 1 : $clog2(CICLOS_POR_BIT + 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CICLOS_POR_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE = BW'(1);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    indice_q, indice_d;
  logic [5:0]    quadro_q, quadro_d;
  logic          serial_q, serial_d;
  logic          fim_bit;
  logic          aceite;

  assign fim_bit = (baud_q == BAUD_MAX);
  assign aceite  = valido && (estado_q == OCIOSO);

  // Next-state, counters, word register and the registered line value.
  always_comb begin
    estado_d = estado_q;
    baud_d   = baud_q;
    indice_d = indice_q;
    quadro_d = quadro_q;
    serial_d = 1'b1;

    case (estado_q)
      OCIOSO: begin
        baud_d = '0;
        if (aceite) begin
          estado_d = INICIO;
          quadro_d = {^dados, dados};
        end
      end
      INICIO: begin
        baud_d = fim_bit ? '0 : baud_q + BAUD_ONE;
        if (fim_bit) begin
          estado_d = DADOS;
          indice_d = 3'd0;
        end
      end
      DADOS: begin
        baud_d = fim_bit ? '0 : baud_q + BAUD_ONE;
        if (fim_bit) begin
          if (indice_q == 3'd4) begin
            estado_d = PARIDADE;
          end else begin
            indice_d = indice_q + 3'd1;
          end
        end
      end
      PARIDADE: begin
        baud_d = fim_bit ? '0 : baud_q + BAUD_ONE;
        if (fim_bit) begin
          estado_d = PARADA;
        end
      end
      PARADA: begin
        baud_d = fim_bit ? '0 : baud_q + BAUD_ONE;
        if (fim_bit) begin
          estado_d = OCIOSO;
        end
      end
      default: begin
        estado_d = OCIOSO;
        baud_d   = '0;
        indice_d = 3'd0;
      end
    endcase

    // The line value is computed from the next state so the flop output
    // lines up exactly with the state it represents.
    case (estado_d)
      INICIO:   serial_d = 1'b0;
      DADOS:    serial_d = quadro_d[indice_d];
      PARIDADE: serial_d = quadro_d[5];
      default:  serial_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      baud_q   <= '0;
      indice_q <= 3'd0;
      quadro_q <= 6'b000000;
      serial_q <= 1'b1;
    end else begin
      estado_q <= estado_d;
      baud_q   <= baud_d;
      indice_q <= indice_d;
      quadro_q <= quadro_d;
      serial_q <= serial_d;
    end
  end

  assign pronto     = (estado_q == OCIOSO);
  assign ocupado    = !pronto;
  assign serial_out = serial_q;
  assign quadro     = quadro_q;
  assign estado_dbg = estado_q;

endmodule

// File: tb/tb_transmissor_paridade.sv
// Bench for transmissor_paridade: three instances (C=4, C=1, C=2) share the
// clock and reset; sel picks which one receives valido and is observed.
module tb_transmissor_paridade;

  logic       clk;
  logic       reset;
  logic [4:0] dados;
  logic       valido;
  int         sel;
  int         cur_c;

  logic       pronto4, serial4, ocupado4;
  logic       pronto1, serial1, ocupado1;
  logic       pronto2, serial2, ocupado2;
  logic [5:0] quadro4, quadro1, quadro2;
  logic [2:0] est4, est1, est2;

  logic       obs_pronto, obs_serial, obs_ocupado;
  logic [5:0] obs_quadro;

  int n_checks;
  int n_fail;

  transmissor_paridade #(.CICLOS_POR_BIT(4)) u_c4 (
    .clk(clk), .reset(reset), .dados(dados), .valido(valido && (sel == 4)),
    .pronto(pronto4), .serial_out(serial4), .ocupado(ocupado4),
    .quadro(quadro4), .estado_dbg(est4)
  );
  transmissor_paridade #(.CICLOS_POR_BIT(1)) u_c1 (
    .clk(clk), .reset(reset), .dados(dados), .valido(valido && (sel == 1)),
    .pronto(pronto1), .serial_out(serial1), .ocupado(ocupado1),
    .quadro(quadro1), .estado_dbg(est1)
  );
  transmissor_paridade #(.CICLOS_POR_BIT(2)) u_c2 (
    .clk(clk), .reset(reset), .dados(dados), .valido(valido && (sel == 2)),
    .pronto(pronto2), .serial_out(serial2), .ocupado(ocupado2),
    .quadro(quadro2), .estado_dbg(est2)
  );

  // Observation mux for the selected instance.
  always_comb begin
    obs_pronto  = pronto4;
    obs_serial  = serial4;
    obs_ocupado = ocupado4;
    obs_quadro  = quadro4;
    if (sel == 1) begin
      obs_pronto = pronto1; obs_serial = serial1; obs_ocupado = ocupado1; obs_quadro = quadro1;
    end else if (sel == 2) begin
      obs_pronto = pronto2; obs_serial = serial2; obs_ocupado = ocupado2; obs_quadro = quadro2;
    end
  end

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent parity checker for loopback: valid when the parity bit
  // equals the XOR of the five data bits.
  function automatic logic checker_valid(input logic [5:0] q);
    int ones = 0;
    for (int i = 0; i < 5; i++) ones += int'(q[i]);
    return ((ones % 2) == int'(q[5]));
  endfunction

  // Offer one word; waits (bounded) for pronto, accept happens at the next edge.
  task automatic send_word(input logic [4:0] d, input bit hold);
    int n = 0;
    @(negedge clk);
    while (obs_pronto !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    dados  = d;
    valido = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valido = 1'b0;
  endtask

  // Samples the line at every negedge for the 8*C frame cycles after accept.
  task automatic capture_frame(output logic [7:0] line, output bit stable,
                               output bit busy_ok, input bit change,
                               input logic [4:0] nd);
    line = '0;
    stable = 1'b1;
    busy_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < cur_c; j++) begin
        @(negedge clk);
        if (j == 0) line[k] = obs_serial;
        else if (obs_serial !== line[k]) stable = 1'b0;
        if (obs_ocupado !== 1'b1 || obs_pronto !== 1'b0) busy_ok = 1'b0;
        if (change && k == 1 && j == 0) dados = nd;
      end
    end
  endtask

  task automatic test_reset;
    sel = 4; cur_c = 4;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs_serial !== 1'b1 || obs_pronto !== 1'b1 || obs_ocupado !== 1'b0 || obs_quadro !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_async: serial=%b pronto=%b ocupado=%b quadro=%b, want 1 1 0 000000",
               obs_serial, obs_pronto, obs_ocupado, obs_quadro);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs_serial !== 1'b1 || obs_pronto !== 1'b1 || obs_ocupado !== 1'b0 || obs_quadro !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_idle_hold: serial=%b pronto=%b ocupado=%b quadro=%b, want 1 1 0 000000",
               obs_serial, obs_pronto, obs_ocupado, obs_quadro);
    end
  endtask

  task automatic test_single_frame;
    logic [7:0] line;
    bit stable, busy_ok;
    sel = 4; cur_c = 4;
    send_word(5'b10110, 1'b0);
    capture_frame(line, stable, busy_ok, 1'b0, 5'b00000);
    n_checks++;
    if (obs_quadro !== 6'b110110) begin
      n_fail++;
      $display("FAIL single_quadro: got %b want 110110", obs_quadro);
    end
    n_checks++;
    if (line !== 8'b11101100 || !stable) begin
      n_fail++;
      $display("FAIL single_line: got %b (k7..k0) stable=%0d want 11101100 stable=1", line, stable);
    end
    n_checks++;
    if (!busy_ok) begin
      n_fail++;
      $display("FAIL single_busy: ocupado/pronto not 1/0 during frame, want 1/0");
    end
    @(negedge clk);
    n_checks++;
    if (obs_pronto !== 1'b1 || obs_ocupado !== 1'b0 || obs_serial !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pronto_e33: pronto=%b ocupado=%b serial=%b want 1 0 1",
               obs_pronto, obs_ocupado, obs_serial);
    end
  endtask

  task automatic test_parity_extremes;
    logic [7:0] line;
    bit stable, busy_ok;
    sel = 1; cur_c = 1;
    send_word(5'b00000, 1'b0);
    capture_frame(line, stable, busy_ok, 1'b0, 5'b00000);
    n_checks++;
    if (obs_quadro !== 6'b000000 || line !== 8'b10000000 || !busy_ok) begin
      n_fail++;
      $display("FAIL parity_zero: quadro=%b line=%b busy=%0d want 000000 10000000 1",
               obs_quadro, line, busy_ok);
    end
    n_checks++;
    if (checker_valid(obs_quadro) !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_zero_check: checker valid=0 for %b, want 1", obs_quadro);
    end
    send_word(5'b11111, 1'b0);
    capture_frame(line, stable, busy_ok, 1'b0, 5'b00000);
    n_checks++;
    if (obs_quadro !== 6'b111111 || line !== 8'b11111110 || !busy_ok) begin
      n_fail++;
      $display("FAIL parity_ones: quadro=%b line=%b busy=%0d want 111111 11111110 1",
               obs_quadro, line, busy_ok);
    end
    n_checks++;
    if (checker_valid(obs_quadro) !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_ones_check: checker valid=0 for %b, want 1", obs_quadro);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] line;
    bit stable, busy_ok;
    sel = 4; cur_c = 4;
    send_word(5'b00001, 1'b1);
    capture_frame(line, stable, busy_ok, 1'b1, 5'b11110);
    n_checks++;
    if (line !== 8'b11000010 || !stable || obs_quadro !== 6'b100001) begin
      n_fail++;
      $display("FAIL busy_frame: line=%b stable=%0d quadro=%b want 11000010 1 100001",
               line, stable, obs_quadro);
    end
    n_checks++;
    if (!busy_ok) begin
      n_fail++;
      $display("FAIL busy_ignore: second word taken during frame, want ignored");
    end
    @(negedge clk); // cycle E+8C+1: idle gap, second accept at the coming edge
    n_checks++;
    if (obs_pronto !== 1'b1 || obs_serial !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: pronto=%b serial=%b want 1 1", obs_pronto, obs_serial);
    end
    @(posedge clk);
    #1 valido = 1'b0;
    // first negedge of capture is E+8C+2, the second frame's start bit
    capture_frame(line, stable, busy_ok, 1'b0, 5'b00000);
    n_checks++;
    if (line !== 8'b10111100 || !stable || obs_quadro !== 6'b011110 || !busy_ok) begin
      n_fail++;
      $display("FAIL b2b_second: line=%b stable=%0d quadro=%b busy=%0d want 10111100 1 011110 1",
               line, stable, obs_quadro, busy_ok);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] line;
    bit stable, busy_ok;
    sel = 4; cur_c = 4;
    send_word(5'b10101, 1'b0);
    repeat (14) @(negedge clk); // inside data bit 2 (frame bit 3)
    n_checks++;
    if (obs_serial !== 1'b1 || obs_ocupado !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_before_reset: serial=%b ocupado=%b want 1 1", obs_serial, obs_ocupado);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs_serial !== 1'b1 || obs_pronto !== 1'b1 || obs_ocupado !== 1'b0 || obs_quadro !== 6'b000000) begin
      n_fail++;
      $display("FAIL mid_reset: serial=%b pronto=%b ocupado=%b quadro=%b want 1 1 0 000000",
               obs_serial, obs_pronto, obs_ocupado, obs_quadro);
    end
    @(negedge clk);
    reset = 1'b0;
    send_word(5'b01010, 1'b0);
    capture_frame(line, stable, busy_ok, 1'b0, 5'b00000);
    n_checks++;
    if (line !== 8'b10010100 || !stable || obs_quadro !== 6'b001010 || !busy_ok) begin
      n_fail++;
      $display("FAIL mid_new_frame: line=%b stable=%0d quadro=%b busy=%0d want 10010100 1 001010 1",
               line, stable, obs_quadro, busy_ok);
    end
  endtask

  task automatic test_loopback_sweep;
    logic [7:0] line, exp_line;
    logic [5:0] exp_q;
    bit stable, busy_ok;
    bit flip_ok;
    sel = 2; cur_c = 2;
    for (int d = 0; d < 32; d++) begin
      logic [4:0] dv;
      dv = 5'(d);
      exp_q = {dv[0] ^ dv[1] ^ dv[2] ^ dv[3] ^ dv[4], dv};
      exp_line = {1'b1, exp_q[5], dv[4], dv[3], dv[2], dv[1], dv[0], 1'b0};
      send_word(dv, 1'b0);
      capture_frame(line, stable, busy_ok, 1'b0, 5'b00000);
      n_checks++;
      if (obs_quadro !== exp_q || line !== exp_line || !stable || !busy_ok) begin
        n_fail++;
        $display("FAIL sweep_d%0d: quadro=%b line=%b want %b %b", d, obs_quadro, line, exp_q, exp_line);
      end
      n_checks++;
      if (checker_valid(obs_quadro) !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_check_d%0d: checker valid=0 for %b, want 1", d, obs_quadro);
      end
      flip_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
        logic [5:0] f;
        f = obs_quadro;
        f[i] = ~f[i];
        if (checker_valid(f) !== 1'b0) flip_ok = 1'b0;
      end
      n_checks++;
      if (!flip_ok) begin
        n_fail++;
        $display("FAIL sweep_flip_d%0d: single-bit flip of %b still valid, want 0", d, obs_quadro);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    dados    = 5'b00000;
    valido   = 1'b0;
    sel      = 4;
    cur_c    = 4;
    test_reset;
    test_single_frame;
    test_parity_extremes;
    test_back_to_back;
    test_reset_mid_frame;
    test_loopback_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/transmissor_paridade.md
# transmissor_paridade

- Transmit-side counterpart of the 6-bit parity check in the link path.
- Accepts a 5-bit data word over a valid/ready handshake and appends an even-parity bit.
- Serialises the word as a framed bit stream (start, 5 data bits LSB first, parity, stop).
- Also presents the registered 6-bit parallel word for loopback into the parity checker.

## Interface

Parameters:
- CICLOS_POR_BIT, default 4: clock cycles per serial bit period; legal range 1..255.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- dados  input  5  data word to transmit; sampled only on the accept cycle.
- valido  input  1  requester has a word on dados.
- pronto  output  1  block can accept a word this cycle.
- serial_out  output  1  serial line; idles high.
- ocupado  output  1  high while a frame is on the line.
- quadro  output  6  registered word {paridade, dados}; paridade is at bit 5.

## Operation

States:
- OCIOSO: pronto=1, ocupado=0, serial_out=1.
  - Accept occurs when valido && pronto at a rising edge.
  - On accept, go to INICIO.
  - On accept, quadro is loaded with {^dados, dados}, i.e. bit 5 = XOR of dados[4:0].
  - The low 6 bits of any quadro therefore always pass the even-parity check: popcount(quadro[4:0]) mod 2 == quadro[5].
- INICIO: serial_out=0 for one bit period, then go to DADOS with the bit index at 0.
- DADOS: serial_out=quadro[indice] for one bit period per bit, indices 0..4 in that order; after index 4, go to PARIDADE.
- PARIDADE: serial_out=quadro[5] for one bit period, then go to PARADA.
- PARADA: serial_out=1 for one bit period, then go to OCIOSO.

Counters and registers:
- Baud counter counts 0..CICLOS_POR_BIT-1 and wraps; it is sized ceil(log2(CICLOS_POR_BIT+1)), minimum 1 bit.
- A bit period ends when the baud counter equals CICLOS_POR_BIT-1.
- Bit index is 3 bits, range 0..4; it is cleared on entry to DADOS.
- Shift or index logic reads from the registered quadro only. Changes on dados after the accept edge have no effect on the frame.

Outputs:
- pronto = (state == OCIOSO).
- ocupado = !pronto.
- serial_out is registered (no glitches) and is driven by state, index and quadro.

Other rules:
- valido while ocupado=1 is ignored; no word is queued or dropped silently, because the requester holds valido until it sees pronto.
- quadro holds its value after the frame ends, until the next accept.
- Reset, asynchronous and usable at any time including mid-frame:
  - state=OCIOSO, serial_out=1, pronto=1, ocupado=0, quadro=6'b000000, counters=0.
  - A partially sent frame is abandoned, with no stop bit added.

## Timing

- Accept at edge E: serial_out goes low (start bit) from E+1.
- A frame lasts 8×CICLOS_POR_BIT cycles: start, 5 data, parity, stop.
- Bit k of the frame (k=0 start … 7 stop) is driven during cycles E+1+k·C through E+(k+1)·C, where C = CICLOS_POR_BIT.
- quadro is valid from E+1.
- ocupado=1 and pronto=0 from E+1 through E+8C; pronto=1 again at E+8C+1.
- Back-to-back with valido held high: the next accept is at edge E+8C+1, so the next start bit appears at E+8C+2. This leaves at least one idle-high cycle between frames.
- C=1 is legal: one cycle per bit, 8-cycle frames.

## Test plan

- Reset idle: assert reset mid-cycle with no clock edge → serial_out=1, pronto=1, ocupado=0, quadro=000000 immediately; these hold with valido=0.
- Single frame, C=4: dados=5'b10110, valido pulse accepted at E →
  - quadro=6'b110110.
  - serial_out per bit = 0,0,1,1,0,1,1,1, each held 4 cycles starting at E+1.
  - pronto returns at E+33.
- Parity extremes, C=1:
  - dados=5'b00000 → quadro=000000, line 0,0,0,0,0,0,0,1.
  - dados=5'b11111 → quadro=111111, line 0,1,1,1,1,1,1,1.
  - Both quadro values pass the parity checker (valid=1).
- Busy ignore and data stability: accept 5'b00001, then change dados to 5'b11110 with valido=1 during the frame →
  - the frame still carries 0,1,0,0,0,0,1,1 and quadro=100001.
  - the second word is accepted only at E+8C+1.
- Reset mid-frame: assert reset during the DADOS bit 2 period → serial_out=1 and pronto=1 at once. After release, a new accept of 5'b01010 produces a clean frame with quadro=001010.
- Loopback sweep: all 32 dados values at C=2 → each quadro drives the parity checker to valid=1. Flipping any single quadro bit into the checker gives valid=0.
